// File: rtl/lsu_mem_pkg.sv
// Shared types for the LSU memory responder: FSM states, latched request record, LFSR seed.
// No logic; imported by lsu_mem_responder and lsu_mem_lfsr8.
// Backpressure: n/a.
package lsu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } lsu_mem_state_e;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  wmask;
    } lsu_mem_req_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Physical memory is word addressed; the low two address bits never reach it.
    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/lsu_mem_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seeded on reset, steps when en=1.
// Latency: next value visible the cycle after en. Backpressure: none.
// Exists only when LSU_MEM_RAND_DELAY_EN is defined.
`ifdef LSU_MEM_RAND_DELAY_EN
module lsu_mem_lfsr8
    import lsu_mem_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    output logic [7:0] lfsr_q
);

    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule
`endif

// File: rtl/lsu_mem_responder.sv
// LSU memory responder: one request at a time, single pmem access per request (pmem_*_vld strobe).
// Latency: resp_valid LATENCY cycles after accept (LATENCY..LATENCY+3 with LSU_MEM_RAND_DELAY_EN).
// Backpressure: response held until resp_ready; next request accepted one cycle after retirement.
module lsu_mem_responder
    import lsu_mem_pkg::*;
#(
    parameter int unsigned LATENCY   = 3,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] MEM_SIZE  = 32'h0800_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    // Physical memory port: one-cycle strobes; read data must be returned in the same cycle.
    output logic        pmem_rd_vld,
    output logic        pmem_wr_vld,
    output logic [31:0] pmem_addr,
    output logic [31:0] pmem_wdata,
    output logic [7:0]  pmem_wmask,
    input  logic [31:0] pmem_rdata
);

    localparam int CNT_W = $clog2(LATENCY + 4);

    lsu_mem_state_e   state_q, state_d;
    lsu_mem_req_t     req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_load;
    logic             req_ready_q, req_ready_d;
    logic [31:0]      resp_rdata_q, resp_rdata_d;
    logic             resp_err_q, resp_err_d;
    logic             addr_err;

`ifdef LSU_MEM_RAND_DELAY_EN
    logic       accept;
    logic [7:0] lfsr_val;
    logic       unused_lfsr_hi;

    assign accept = (state_q == IDLE) && req_valid && req_ready_q;

    lsu_mem_lfsr8 u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .en     (accept),
        .lfsr_q (lfsr_val)
    );

    // Only the two LSBs stretch BUSY; the rest of the state just drives the sequence.
    assign unused_lfsr_hi = ^lfsr_val[7:2];
    assign cnt_load       = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_val[1:0]);
`else
    assign cnt_load = CNT_W'(LATENCY - 1);
`endif

    // Unsigned compare; the subtraction cannot wrap because the first term short-circuits it.
    assign addr_err = (req_q.addr < BASE_ADDR) || ((req_q.addr - BASE_ADDR) >= MEM_SIZE);

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        cnt_d        = cnt_q;
        req_ready_d  = req_ready_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        pmem_rd_vld  = 1'b0;
        pmem_wr_vld  = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    req_d       = '{wen: req_wen, addr: req_addr, wdata: req_wdata, wmask: req_wmask};
                    cnt_d       = cnt_load;
                    req_ready_d = 1'b0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                req_ready_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d      = RESP;
                    resp_err_d   = addr_err;
                    resp_rdata_d = 32'h0;
                    if (!addr_err) begin
                        // Strobes are masked by reset so an aborted request never reaches memory.
                        if (req_q.wen) begin
                            pmem_wr_vld = reset;
                        end else begin
                            pmem_rd_vld  = reset;
                            resp_rdata_d = pmem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                req_ready_d = 1'b0;
                if (resp_ready) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            req_q        <= '0;
            cnt_q        <= '0;
            req_ready_q  <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign pmem_addr  = word_addr(req_q.addr);
    assign pmem_wdata = req_q.wdata;
    assign pmem_wmask = req_q.wmask;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Bench for lsu_mem_responder: directed vector table, hold/reset sequences, randomized traffic
// checked against an address-keyed reference memory; the pmem model counts read/write calls.
module tb_lsu_mem_responder;

    localparam int unsigned LAT  = 3;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] SIZE = 32'h0800_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        pmem_rd_vld, pmem_wr_vld;
    logic [31:0] pmem_addr, pmem_wdata, pmem_rdata;
    logic [7:0]  pmem_wmask;

    int n_checks = 0;
    int n_errors = 0;
    int rd_calls = 0;
    int wr_calls = 0;
    logic [31:0] last_addr  = 32'h0;
    logic [7:0]  last_wmask = 8'h0;
    bit lat_seen [4];

    logic [31:0] mem [0:255] = '{default: 32'h0};
    bit [31:0] ref_mem [bit [31:0]];

    always #5 clock = ~clock;

    lsu_mem_responder #(.LATENCY(LAT), .BASE_ADDR(BASE), .MEM_SIZE(SIZE)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wen     (req_wen),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wmask   (req_wmask),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .pmem_rd_vld (pmem_rd_vld),
        .pmem_wr_vld (pmem_wr_vld),
        .pmem_addr   (pmem_addr),
        .pmem_wdata  (pmem_wdata),
        .pmem_wmask  (pmem_wmask),
        .pmem_rdata  (pmem_rdata)
    );

    // Physical memory model: combinational read, byte-masked write on the low four mask bits.
    assign pmem_rdata = mem[pmem_addr[9:2]];

    always @(posedge clock) begin
        if (pmem_wr_vld) begin
            for (int b = 0; b < 4; b++) begin
                if (pmem_wmask[b]) mem[pmem_addr[9:2]][8*b +: 8] <= pmem_wdata[8*b +: 8];
            end
            wr_calls   = wr_calls + 1;
            last_addr  = pmem_addr;
            last_wmask = pmem_wmask;
        end
        if (pmem_rd_vld) begin
            rd_calls  = rd_calls + 1;
            last_addr = pmem_addr;
        end
    end

    function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endfunction

    function automatic void chk_lat(input string name, input int lat);
        n_checks++;
`ifdef LSU_MEM_RAND_DELAY_EN
        if (lat >= int'(LAT) && lat <= int'(LAT) + 3) begin
            lat_seen[lat - int'(LAT)] = 1'b1;
        end else begin
            n_errors++;
            $display("FAIL %s.latency: got %0d, expected %0d..%0d", name, lat, LAT, LAT + 3);
        end
`else
        if (lat != int'(LAT)) begin
            n_errors++;
            $display("FAIL %s.latency: got %0d, expected %0d", name, lat, LAT);
        end
`endif
    endfunction

    // Reference: the valid window expressed with 64-bit bounds, memory as a sparse word map.
    function automatic bit ref_err(input logic [31:0] a);
        longint unsigned x, lo, hi;
        x  = longint'(a);
        lo = longint'(BASE);
        hi = lo + longint'(SIZE);
        return !(x >= lo && x < hi);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a);
        bit [31:0] k;
        k = {a[31:2], 2'b00};
        return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
    endfunction

    function automatic void ref_store(input logic [31:0] a, input logic [31:0] d, input logic [7:0] m);
        bit [31:0] k, w;
        k = {a[31:2], 2'b00};
        w = ref_load(a);
        for (int b = 0; b < 4; b++) begin
            if (m[b]) w[8*b +: 8] = d[8*b +: 8];
        end
        ref_mem[k] = w;
    endfunction

    // Accepts at the next edge with req_ready high; leaves req_valid high with junk while BUSY.
    task automatic send(input bit wen, input logic [31:0] addr, input logic [31:0] wdata, input logic [7:0] wmask);
        int guard;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 40) begin
            @(posedge clock); #1;
            guard++;
        end
        if (guard >= 40) chk1("send.req_ready_timeout", req_ready, 1'b1);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        @(posedge clock); #1;
        req_wen   = ~wen;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_wmask = 8'($urandom);
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 32) begin
            @(posedge clock); #1;
            lat++;
        end
        req_valid = 1'b0;
    endtask

    task automatic retire(input string name);
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        chk1({name, ".retired"}, resp_valid, 1'b0);
        chk1({name, ".ready_after_retire"}, req_ready, 1'b1);
    endtask

    task automatic run_txn(input string name, input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [7:0] wmask, input logic [31:0] exp_rdata, input bit exp_err);
        int rd0, wr0, lat;
        rd0 = rd_calls;
        wr0 = wr_calls;
        send(wen, addr, wdata, wmask);
        wait_resp(lat);
        chk_lat(name, lat);
        chk32({name, ".rdata"}, resp_rdata, exp_rdata);
        chk1({name, ".err"}, resp_err, exp_err);
        chk32({name, ".rd_calls"}, rd_calls - rd0, (!wen && !exp_err) ? 1 : 0);
        chk32({name, ".wr_calls"}, wr_calls - wr0, (wen && !exp_err) ? 1 : 0);
        if (!exp_err) chk32({name, ".pmem_addr"}, last_addr, {addr[31:2], 2'b00});
        if (wen && !exp_err) chk32({name, ".wmask"}, {24'h0, last_wmask}, {24'h0, wmask});
        retire(name);
        if (wen && !ref_err(addr)) ref_store(addr, wdata, wmask);
    endtask

    typedef struct {
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  wmask;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
        $fatal(1);
    end

    initial begin
        int lat, rd0, wr0;
        logic [31:0] a, hold_rdata;
        bit w;

        vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'h8000_0013, 32'h0,         8'h00, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         8'h00, 32'h0,         1'b1};
        vecs[3]  = '{1'b0, 32'h8800_0000, 32'h0,         8'h00, 32'h0,         1'b1};
        vecs[4]  = '{1'b1, 32'h8000_0010, 32'hCAFE_0000, 8'h03, 32'h0,         1'b0};
        vecs[5]  = '{1'b0, 32'h8000_0012, 32'h0,         8'h00, 32'hDEAD_0000, 1'b0};
        vecs[6]  = '{1'b1, 32'h87FF_FFFC, 32'h1122_3344, 8'h00, 32'h0,         1'b0};
        vecs[7]  = '{1'b1, 32'h8800_0000, 32'h5555_5555, 8'hFF, 32'h0,         1'b1};
        vecs[8]  = '{1'b0, 32'h8000_0000, 32'h0,         8'h00, 32'h0,         1'b0};
        vecs[9]  = '{1'b1, 32'h8000_0014, 32'hA5A5_A5A5, 8'hF0, 32'h0,         1'b0};
        vecs[10] = '{1'b0, 32'h8000_0014, 32'h0,         8'h00, 32'h0,         1'b0};
        vecs[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         8'h00, 32'h0,         1'b1};

        reset = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_wmask = 8'h0; resp_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk1("rst.req_ready", req_ready, 1'b0);
        chk1("rst.resp_valid", resp_valid, 1'b0);
        chk32("rst.resp_rdata", resp_rdata, 32'h0);
        chk1("rst.resp_err", resp_err, 1'b0);
        reset = 1'b1;
        @(posedge clock); #1;
        chk1("rst.req_ready_rise", req_ready, 1'b1);

        for (int i = 0; i < 12; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask,
                    vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Response held for five cycles while a new request waits.
        rd0 = rd_calls;
        send(1'b0, 32'h8000_0010, 32'h0, 8'h0);
        wait_resp(lat);
        chk_lat("hold", lat);
        hold_rdata = resp_rdata;
        chk32("hold.rdata", resp_rdata, ref_load(32'h8000_0010));
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            chk1("hold.resp_valid", resp_valid, 1'b1);
            chk32("hold.rdata_stable", resp_rdata, hold_rdata);
            chk1("hold.req_ready", req_ready, 1'b0);
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        chk1("hold.retired", resp_valid, 1'b0);
        chk1("hold.ready_after_retire", req_ready, 1'b1);
        chk32("hold.rd_calls_before_accept", rd_calls - rd0, 1);
        @(posedge clock); #1;
        chk1("hold.accepted", req_ready, 1'b0);
        wait_resp(lat);
        chk_lat("hold2", lat);
        chk32("hold2.rdata", resp_rdata, ref_load(32'h8000_0010));
        chk32("hold2.rd_calls", rd_calls - rd0, 2);
        retire("hold2");

        // Reset while a store is in BUSY: the write must never reach memory.
        wr0 = wr_calls;
        send(1'b1, 32'h8000_0020, 32'h1234_5678, 8'h0F);
        req_valid = 1'b0;
        repeat (LAT - 1) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        chk32("busy_rst.wr_calls", wr_calls - wr0, 0);
        chk1("busy_rst.req_ready", req_ready, 1'b0);
        chk1("busy_rst.resp_valid", resp_valid, 1'b0);
        chk32("busy_rst.resp_rdata", resp_rdata, 32'h0);
        chk1("busy_rst.resp_err", resp_err, 1'b0);
        reset = 1'b1;
        @(posedge clock); #1;
        chk1("busy_rst.req_ready_rise", req_ready, 1'b1);
        run_txn("busy_rst.load", 1'b0, 32'h8000_0020, 32'h0, 8'h0, ref_load(32'h8000_0020), 1'b0);

        for (int k = 0; k < 4; k++) lat_seen[k] = 1'b0;
        rd0 = rd_calls;
        for (int i = 0; i < 64; i++) begin
            a = BASE + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
            run_txn("rand_ld", 1'b0, a, $urandom, 8'($urandom), ref_load(a), ref_err(a));
        end
        chk32("rand_ld.read_calls", rd_calls - rd0, 64);
`ifdef LSU_MEM_RAND_DELAY_EN
        for (int k = 0; k < 4; k++) chk1($sformatf("rand_ld.lat_seen%0d", k), lat_seen[k], 1'b1);
`endif

        for (int i = 0; i < 48; i++) begin
            case ($urandom_range(0, 4))
                0:       a = BASE - 32'($urandom_range(1, 64) * 4);
                1:       a = BASE + SIZE + 32'($urandom_range(0, 1023));
                default: a = BASE + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
            endcase
            w = 1'($urandom_range(0, 1));
            run_txn("rand_mix", w, a, $urandom, 8'($urandom),
                    (w || ref_err(a)) ? 32'h0 : ref_load(a), ref_err(a));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
